// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared definitions for the memory access unit:
//   state_t              - control FSM states (IDLE, ACCESS, RESP)
//   SIZE_B/SIZE_H/SIZE_W - access size encodings carried on req_size/mem_size
//   SIZE_X               - the reserved (illegal) size encoding
//   CNT_W                - width of the access wait counter (LATENCY up to 15)
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_X = 2'd3;

    localparam int CNT_W = 4;

endpackage : mem_access_pkg

// File: rtl/mem_lane_decode.sv
// mem_lane_decode
// Purely combinational decode of a request's low address bits and size.
// Ports:
//   addr_lo  in  2  byte offset within the 32-bit word (addr[1:0])
//   size     in  2  access size (SIZE_B/SIZE_H/SIZE_W, SIZE_X illegal)
//   wstrb    out 4  byte-lane enables, size mask shifted to the byte offset
//   misalign out 1  illegal size, or half/word not naturally aligned
module mem_lane_decode
    import mem_access_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [1:0] size,
    output logic [3:0] wstrb,
    output logic       misalign
);

    logic [3:0] base_mask;

    always_comb begin
        base_mask = 4'b0000;
        misalign  = 1'b0;
        case (size)
            SIZE_B: begin
                base_mask = 4'b0001;
            end
            SIZE_H: begin
                base_mask = 4'b0011;
                misalign  = addr_lo[0];
            end
            SIZE_W: begin
                base_mask = 4'b1111;
                misalign  = (addr_lo != 2'b00);
            end
            default: begin
                misalign  = 1'b1;
            end
        endcase
    end

    // Lanes shifted past bit 3 fall off; that only happens for misaligned
    // requests, which never reach the memory.
    assign wstrb = base_mask << addr_lo;

endmodule : mem_lane_decode

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store unit between a pipeline and a simple memory port. One request
// is accepted in IDLE, held on the memory port for LATENCY cycles in ACCESS,
// then presented as a response in RESP until the pipeline takes it.
// Misaligned or illegal-size requests skip the memory and respond at once
// with resp_misalign set.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. req_ready is 1 only in IDLE; resp_valid is 1 only in RESP and
// the response fields stay stable until resp_ready. A response consumed at
// an edge returns the unit to IDLE, so a new request is accepted no earlier
// than the following edge.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   req_valid/req_ready     request handshake
//   req_addr/wen/signed/size/wdata  request fields
//   resp_valid/resp_ready   response handshake
//   resp_rdata, resp_misalign       response fields
//   mem_addr/wdata/size     latched request presented to memory
//   mem_read/read_signed/write, mem_wstrb  memory strobes (ACCESS only)
//   mem_rdata               combinational read data from memory
//   fsm_state               current FSM state for observation
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int LATENCY = 1
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic        req_signed,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_read_signed,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  fsm_state
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;

    logic [31:0]       lat_addr;
    logic              lat_wen;
    logic              lat_signed;
    logic [1:0]        lat_size;
    logic [31:0]       lat_wdata;

    logic [1:0]        dec_addr_lo;
    logic [1:0]        dec_size;
    logic [3:0]        dec_wstrb;
    logic              dec_misalign;

    logic              in_access;
    logic              last_cycle;

    // One decoder serves both phases: in IDLE it judges the incoming request,
    // afterwards it produces the lane strobes of the latched request.
    assign dec_addr_lo = (state == ST_IDLE) ? req_addr[1:0] : lat_addr[1:0];
    assign dec_size    = (state == ST_IDLE) ? req_size      : lat_size;

    mem_lane_decode u_lane_decode (
        .addr_lo  (dec_addr_lo),
        .size     (dec_size),
        .wstrb    (dec_wstrb),
        .misalign (dec_misalign)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = dec_misalign ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt == '0) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, wait counter and response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt           <= '0;
            lat_addr      <= '0;
            lat_wen       <= 1'b0;
            lat_signed    <= 1'b0;
            lat_size      <= '0;
            lat_wdata     <= '0;
            resp_rdata    <= '0;
            resp_misalign <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_addr      <= req_addr;
                        lat_wen       <= req_wen;
                        lat_signed    <= req_signed;
                        lat_size      <= req_size;
                        lat_wdata     <= req_wdata;
                        cnt           <= CNT_INIT;
                        resp_misalign <= dec_misalign;
                        resp_rdata    <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        resp_rdata <= lat_wen ? 32'd0 : mem_rdata;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_access  = (state == ST_ACCESS);
    assign last_cycle = in_access && (cnt == '0);

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);

    assign mem_addr        = lat_addr;
    assign mem_wdata       = lat_wdata;
    assign mem_size        = lat_size;
    assign mem_read        = in_access && !lat_wen;
    assign mem_read_signed = in_access && !lat_wen && lat_signed;
    // Gating with reset keeps a reset that lands on the final cycle from
    // committing a store that will never be acknowledged.
    assign mem_write       = last_cycle && lat_wen && !reset;
    assign mem_wstrb       = mem_write ? dec_wstrb : 4'b0000;

    assign fsm_state = state;

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit. Two instances run side by side on shared inputs:
// index 0 with LATENCY=1 and index 1 with LATENCY=3. Each directed vector is
// applied to both and the observed strobes, latency and response are
// compared against hand-computed values; hand-written sequences cover reset,
// response back-pressure and a reset landing on the final store cycle.
module tb_mem_access_unit;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic        sgn;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] mrd;
        logic        exp_mis;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_wstrb;
        logic        exp_rd;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_wen;
    logic        req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_ready;
    logic [31:0] mem_rdata;

    logic        req_ready_x [2];
    logic        resp_valid_x [2];
    logic [31:0] resp_rdata_x [2];
    logic        resp_mis_x [2];
    logic [31:0] mem_addr_x [2];
    logic [31:0] mem_wdata_x [2];
    logic        mem_read_x [2];
    logic        mem_rs_x [2];
    logic        mem_write_x [2];
    logic [1:0]  mem_size_x [2];
    logic [3:0]  mem_wstrb_x [2];
    logic [1:0]  fsm_state_x [2];

    int n_vec  = 0;
    int n_chk  = 0;
    int n_fail = 0;

    vec_t vecs [10];

    always #5 clock = ~clock;

    mem_access_unit #(.LATENCY(1)) dut_l1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_x[0]),
        .req_addr(req_addr), .req_wen(req_wen), .req_signed(req_signed),
        .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid_x[0]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_x[0]), .resp_misalign(resp_mis_x[0]),
        .mem_addr(mem_addr_x[0]), .mem_wdata(mem_wdata_x[0]),
        .mem_read(mem_read_x[0]), .mem_read_signed(mem_rs_x[0]),
        .mem_write(mem_write_x[0]), .mem_size(mem_size_x[0]),
        .mem_wstrb(mem_wstrb_x[0]), .mem_rdata(mem_rdata),
        .fsm_state(fsm_state_x[0])
    );

    mem_access_unit #(.LATENCY(3)) dut_l3 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_x[1]),
        .req_addr(req_addr), .req_wen(req_wen), .req_signed(req_signed),
        .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid_x[1]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_x[1]), .resp_misalign(resp_mis_x[1]),
        .mem_addr(mem_addr_x[1]), .mem_wdata(mem_wdata_x[1]),
        .mem_read(mem_read_x[1]), .mem_read_signed(mem_rs_x[1]),
        .mem_write(mem_write_x[1]), .mem_size(mem_size_x[1]),
        .mem_wstrb(mem_wstrb_x[1]), .mem_rdata(mem_rdata),
        .fsm_state(fsm_state_x[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s d%0d req_ready", tag, d), 32'(req_ready_x[d]), 32'd1);
            check($sformatf("%s d%0d resp_valid", tag, d), 32'(resp_valid_x[d]), 32'd0);
            check($sformatf("%s d%0d mem_strobes", tag, d),
                  {28'd0, mem_read_x[d], mem_rs_x[d], mem_write_x[d], 1'b0} | 32'(mem_wstrb_x[d]), 32'd0);
            check($sformatf("%s d%0d mem_addr", tag, d), mem_addr_x[d], 32'd0);
            check($sformatf("%s d%0d mem_wdata", tag, d), mem_wdata_x[d], 32'd0);
            check($sformatf("%s d%0d mem_size", tag, d), 32'(mem_size_x[d]), 32'd0);
        end
    endtask

    task automatic drive_req(input vec_t v);
        @(negedge clock);
        req_valid  = 1'b1;
        req_addr   = v.addr;
        req_wen    = v.wen;
        req_signed = v.sgn;
        req_size   = v.size;
        req_wdata  = v.wdata;
        mem_rdata  = v.mrd;
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          rd [2];
        int          rs [2];
        int          wr [2];
        int          lat [2];
        logic [31:0] rdat [2];
        logic [31:0] wd [2];
        logic [31:0] wadr [2];
        logic [3:0]  ws [2];
        logic        mis [2];
        logic        busy [2];
        int          exp_lat;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 0; rs[d] = 0; wr[d] = 0; lat[d] = 0;
            rdat[d] = 'x; wd[d] = '0; wadr[d] = '0; ws[d] = '0; mis[d] = 1'bx; busy[d] = 1'b0;
        end
        n_vec++;
        drive_req(v);
        for (int cyc = 1; cyc <= 40 && (lat[0] == 0 || lat[1] == 0); cyc++) begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                if (cyc == 1) busy[d] = !req_ready_x[d];
                if (lat[d] == 0) begin
                    if (mem_read_x[d]) rd[d]++;
                    if (mem_rs_x[d]) rs[d]++;
                    if (mem_write_x[d]) begin
                        wr[d]++;
                        ws[d]   = mem_wstrb_x[d];
                        wd[d]   = mem_wdata_x[d];
                        wadr[d] = mem_addr_x[d];
                    end
                    if (resp_valid_x[d]) begin
                        lat[d]  = cyc;
                        rdat[d] = resp_rdata_x[d];
                        mis[d]  = resp_mis_x[d];
                    end
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            exp_lat = v.exp_mis ? 1 : (d == 0 ? 2 : 4);
            check($sformatf("v%0d d%0d busy", idx, d), 32'(busy[d]), 32'd1);
            check($sformatf("v%0d d%0d latency", idx, d), 32'(lat[d]), 32'(exp_lat));
            check($sformatf("v%0d d%0d rdata", idx, d), rdat[d], v.exp_rdata);
            check($sformatf("v%0d d%0d misalign", idx, d), 32'(mis[d]), 32'(v.exp_mis));
            check($sformatf("v%0d d%0d read_cycles", idx, d), 32'(rd[d]),
                  v.exp_rd ? (d == 0 ? 32'd1 : 32'd3) : 32'd0);
            check($sformatf("v%0d d%0d read_signed_cycles", idx, d), 32'(rs[d]),
                  (v.exp_rd && v.sgn) ? (d == 0 ? 32'd1 : 32'd3) : 32'd0);
            check($sformatf("v%0d d%0d writes", idx, d), 32'(wr[d]),
                  (v.wen && !v.exp_mis) ? 32'd1 : 32'd0);
            check($sformatf("v%0d d%0d wstrb", idx, d), 32'(ws[d]), 32'(v.exp_wstrb));
            if (wr[d] != 0) begin
                check($sformatf("v%0d d%0d wdata", idx, d), wd[d], v.wdata);
                check($sformatf("v%0d d%0d waddr", idx, d), wadr[d], v.addr);
            end
        end
        // Both responses were consumed (resp_ready=1); the next cycle is IDLE.
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("v%0d d%0d ready_after", idx, d), 32'(req_ready_x[d]), 32'd1);
        end
    endtask

    initial begin
        vec_t v;
        int   wr_cnt;
        int   rv_cnt;

        //             addr          wen  sgn  size   wdata         mrd           mis   rdata         wstrb    rd
        vecs[0] = '{32'h8000_0004, 1'b0, 1'b0, 2'd2, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 4'b0000, 1'b1};
        vecs[1] = '{32'h8000_0003, 1'b1, 1'b0, 2'd0, 32'h0000_00AB, 32'h5555_5555, 1'b0, 32'h0,        4'b1000, 1'b0};
        vecs[2] = '{32'h8000_0001, 1'b0, 1'b0, 2'd1, 32'h0,        32'h1234_5678, 1'b1, 32'h0,        4'b0000, 1'b0};
        vecs[3] = '{32'h8000_0010, 1'b1, 1'b0, 2'd2, 32'h1234_5678, 32'h0,        1'b0, 32'h0,        4'b1111, 1'b0};
        vecs[4] = '{32'h8000_0002, 1'b1, 1'b0, 2'd1, 32'h0000_BEEF, 32'h0,        1'b0, 32'h0,        4'b1100, 1'b0};
        vecs[5] = '{32'h8000_0000, 1'b0, 1'b0, 2'd3, 32'h0,        32'hAAAA_AAAA, 1'b1, 32'h0,        4'b0000, 1'b0};
        vecs[6] = '{32'h8000_0002, 1'b0, 1'b0, 2'd2, 32'h0,        32'hAAAA_AAAA, 1'b1, 32'h0,        4'b0000, 1'b0};
        vecs[7] = '{32'h8000_0001, 1'b0, 1'b1, 2'd0, 32'h0,        32'hFFFF_FF80, 1'b0, 32'hFFFF_FF80, 4'b0000, 1'b1};
        vecs[8] = '{32'h8000_0000, 1'b1, 1'b0, 2'd1, 32'h0000_CAFE, 32'h0,        1'b0, 32'h0,        4'b0011, 1'b0};
        vecs[9] = '{32'h8000_0001, 1'b1, 1'b0, 2'd0, 32'h0000_0077, 32'h0,        1'b0, 32'h0,        4'b0010, 1'b0};

        // Clock/reset
        reset      = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 32'h8000_0000;
        req_wen    = 1'b1;
        req_signed = 1'b0;
        req_size   = 2'd2;
        req_wdata  = 32'hFFFF_FFFF;
        resp_ready = 1'b1;
        mem_rdata  = 32'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_idle_outputs("in_reset");
        req_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_idle_outputs("after_reset");

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-pressure: response held with resp_ready=0
        v = '{32'h8000_0008, 1'b0, 1'b0, 2'd2, 32'h0, 32'h1122_3344, 1'b0, 32'h1122_3344, 4'b0000, 1'b1};
        n_vec++;
        resp_ready = 1'b0;
        drive_req(v);
        for (int cyc = 0; cyc < 20 && !(resp_valid_x[0] && resp_valid_x[1]); cyc++) begin
            @(negedge clock);
        end
        mem_rdata = 32'h0;
        for (int k = 0; k < 5; k++) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("hold%0d d%0d resp_valid", k, d), 32'(resp_valid_x[d]), 32'd1);
                check($sformatf("hold%0d d%0d rdata", k, d), resp_rdata_x[d], 32'h1122_3344);
                check($sformatf("hold%0d d%0d req_ready", k, d), 32'(req_ready_x[d]), 32'd0);
            end
            @(negedge clock);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("hold_release d%0d req_ready", d), 32'(req_ready_x[d]), 32'd1);
            check($sformatf("hold_release d%0d resp_valid", d), 32'(resp_valid_x[d]), 32'd0);
        end

        // Reset on the final ACCESS cycle of a LATENCY=3 store
        v = '{32'h8000_0010, 1'b1, 1'b0, 2'd2, 32'hCAFE_F00D, 32'h0, 1'b0, 32'h0, 4'b1111, 1'b0};
        n_vec++;
        wr_cnt = 0;
        rv_cnt = 0;
        drive_req(v);                       // returns #1 after accept edge N
        @(posedge clock);                   // edge N+1
        @(posedge clock);                   // edge N+2: now in last ACCESS cycle
        #1 reset = 1'b1;
        @(negedge clock);
        check("rst_last d1 mem_write", 32'(mem_write_x[1]), 32'd0);
        check("rst_last d1 mem_wstrb", 32'(mem_wstrb_x[1]), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_last d1 req_ready", 32'(req_ready_x[1]), 32'd1);
        check("rst_last d1 resp_rdata", resp_rdata_x[1], 32'd0);
        for (int k = 0; k < 6; k++) begin
            if (mem_write_x[1]) wr_cnt++;
            if (resp_valid_x[1]) rv_cnt++;
            @(negedge clock);
        end
        check("rst_last d1 no_write_after", 32'(wr_cnt), 32'd0);
        check("rst_last d1 no_resp", 32'(rv_cnt), 32'd0);

        // Unit still works after the aborted store
        run_vec(10, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_mem_access_unit
